// File: rtl/rs_bank.sv
// rs_bank: reservation-station bank with CDB wakeup and single-issue dispatch.
// Optional feature macro RS_AGE_ORDER_EN: when defined, dispatch the oldest
// ready entry using per-entry ages; otherwise dispatch the lowest-index ready entry.
module rs_bank #(
    parameter int ENTRIES = 4,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 4,
    parameter int CDB_N   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [OP_W-1:0]               issue_op,
    input  logic [XLEN-1:0]               issue_vj,
    input  logic [XLEN-1:0]               issue_vk,
    input  logic [TAG_W-1:0]              issue_qj,
    input  logic [TAG_W-1:0]              issue_qk,
    input  logic [TAG_W-1:0]              issue_dst,
    input  logic [CDB_N-1:0]              cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]        cdb_tag,
    input  logic [CDB_N*XLEN-1:0]         cdb_data,
    output logic                          disp_valid,
    input  logic                          disp_ready,
    output logic [OP_W-1:0]               disp_op,
    output logic [XLEN-1:0]               disp_vj,
    output logic [XLEN-1:0]               disp_vk,
    output logic [TAG_W-1:0]              disp_dst,
    output logic [$clog2(ENTRIES+1)-1:0]  count
);
    localparam int AW = $clog2(ENTRIES);
    localparam int CW = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0] r_valid;
    logic [OP_W-1:0]    r_op  [ENTRIES];
    logic [XLEN-1:0]    r_vj  [ENTRIES];
    logic [XLEN-1:0]    r_vk  [ENTRIES];
    logic [TAG_W-1:0]   r_qj  [ENTRIES];
    logic [TAG_W-1:0]   r_qk  [ENTRIES];
    logic [TAG_W-1:0]   r_dst [ENTRIES];
    logic [CW-1:0]      r_count;
`ifdef RS_AGE_ORDER_EN
    logic [AW-1:0]      r_age [ENTRIES];
    logic [AW-1:0]      w_sel_age;
`endif

    logic [ENTRIES-1:0] w_rdy;
    logic [ENTRIES-1:0] w_jhit;
    logic [ENTRIES-1:0] w_khit;
    logic [XLEN-1:0]    w_jdata [ENTRIES];
    logic [XLEN-1:0]    w_kdata [ENTRIES];
    logic               w_ij_hit;
    logic               w_ik_hit;
    logic [XLEN-1:0]    w_ij_data;
    logic [XLEN-1:0]    w_ik_data;
    logic               w_found;
    logic [AW-1:0]      w_sel;
    logic [AW-1:0]      w_free;
    logic               w_disp_valid;
    logic               w_disp_fire;
    logic               w_issue_fire;

    // Search the CDB lanes for a tag; lowest matching lane wins, tag 0 never matches.
    function automatic logic cdb_match(input logic [TAG_W-1:0] tag, output logic [XLEN-1:0] data);
        cdb_match = 1'b0;
        data = '0;
        for (int l = CDB_N - 1; l >= 0; l--) begin
            if (tag != '0 && cdb_valid[l] && cdb_tag[l*TAG_W +: TAG_W] == tag) begin
                cdb_match = 1'b1;
                data = cdb_data[l*XLEN +: XLEN];
            end
        end
    endfunction

    // Per-entry wakeup, readiness from registered state, lowest free slot, issue-time bypass.
    always_comb begin
        w_free = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            w_rdy[i]  = r_valid[i] && r_qj[i] == '0 && r_qk[i] == '0;
            w_jhit[i] = r_valid[i] & cdb_match(r_qj[i], w_jdata[i]);
            w_khit[i] = r_valid[i] & cdb_match(r_qk[i], w_kdata[i]);
            if (!r_valid[i])
                w_free = AW'(i);
        end
        w_ij_hit = cdb_match(issue_qj, w_ij_data);
        w_ik_hit = cdb_match(issue_qk, w_ik_data);
    end

`ifdef RS_AGE_ORDER_EN
    // Pick the ready entry with the largest age (oldest issued).
    always_comb begin
        w_found   = 1'b0;
        w_sel     = '0;
        w_sel_age = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_rdy[i] && (!w_found || r_age[i] > w_sel_age)) begin
                w_found   = 1'b1;
                w_sel     = AW'(i);
                w_sel_age = r_age[i];
            end
        end
    end
`else
    // Pick the lowest-index ready entry.
    always_comb begin
        w_found = |w_rdy;
        w_sel   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_rdy[i])
                w_sel = AW'(i);
        end
    end
`endif

    assign issue_ready  = r_count < CW'(ENTRIES);
    assign w_disp_valid = w_found && !flush;
    assign w_disp_fire  = w_disp_valid && disp_ready;
    assign w_issue_fire = issue_valid && issue_ready && !flush;

    assign disp_valid = w_disp_valid;
    assign disp_op    = w_disp_valid ? r_op[w_sel]  : '0;
    assign disp_vj    = w_disp_valid ? r_vj[w_sel]  : '0;
    assign disp_vk    = w_disp_valid ? r_vk[w_sel]  : '0;
    assign disp_dst   = w_disp_valid ? r_dst[w_sel] : '0;
    assign count      = r_count;

    // Entry storage: wakeup capture, dispatch free, issue write, occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_op[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_dst[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_jhit[i]) begin
                    r_vj[i] <= w_jdata[i];
                    r_qj[i] <= '0;
                end
                if (w_khit[i]) begin
                    r_vk[i] <= w_kdata[i];
                    r_qk[i] <= '0;
                end
                if (w_disp_fire && w_sel == AW'(i))
                    r_valid[i] <= 1'b0;
            end
            if (w_issue_fire) begin
                r_valid[w_free] <= 1'b1;
                r_op[w_free]    <= issue_op;
                r_dst[w_free]   <= issue_dst;
                r_vj[w_free]    <= w_ij_hit ? w_ij_data : issue_vj;
                r_vk[w_free]    <= w_ik_hit ? w_ik_data : issue_vk;
                r_qj[w_free]    <= w_ij_hit ? '0 : issue_qj;
                r_qk[w_free]    <= w_ik_hit ? '0 : issue_qk;
            end
            r_count <= r_count + CW'(w_issue_fire) - CW'(w_disp_fire);
        end
    end

`ifdef RS_AGE_ORDER_EN
    // Ages stay compact: older entries close the gap left by a dispatch, all age on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                r_age[i] <= '0;
        end else if (!flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (r_valid[i])
                    r_age[i] <= r_age[i] - AW'(w_disp_fire && r_age[i] > w_sel_age) + AW'(w_issue_fire);
            end
            if (w_issue_fire)
                r_age[w_free] <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: directed and randomized checks of rs_bank against a slot/sequence-number model.
module tb_rs_bank;
    localparam int E = 4;
    localparam int X = 32;
    localparam int T = 4;
    localparam int O = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic           issue_valid;
    logic           issue_ready;
    logic [O-1:0]   issue_op;
    logic [X-1:0]   issue_vj;
    logic [X-1:0]   issue_vk;
    logic [T-1:0]   issue_qj;
    logic [T-1:0]   issue_qk;
    logic [T-1:0]   issue_dst;
    logic [N-1:0]   cdb_valid;
    logic [N*T-1:0] cdb_tag;
    logic [N*X-1:0] cdb_data;
    logic           disp_valid;
    logic           disp_ready;
    logic [O-1:0]   disp_op;
    logic [X-1:0]   disp_vj;
    logic [X-1:0]   disp_vk;
    logic [T-1:0]   disp_dst;
    logic [2:0]     count;

    always #5 clk = ~clk;

    rs_bank #(.ENTRIES(E), .XLEN(X), .TAG_W(T), .OP_W(O), .CDB_N(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_dst(issue_dst), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_dst(disp_dst), .count(count)
    );

    // Model: slots with an issue sequence number; oldest = smallest sequence number.
    bit           m_v   [E];
    logic [O-1:0] m_op  [E];
    logic [X-1:0] m_vj  [E];
    logic [X-1:0] m_vk  [E];
    logic [T-1:0] m_qj  [E];
    logic [T-1:0] m_qk  [E];
    logic [T-1:0] m_dst [E];
    int           m_seq [E];
    int           seqc;
    int           m_cnt;
    int           n_chk;
    int           n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit lane_hit(input logic [T-1:0] tag, output logic [X-1:0] d);
        bit hit;
        hit = 0;
        d = '0;
        for (int l = 0; l < N; l++) begin
            if (!hit && tag != 0 && cdb_valid[l] && cdb_tag[l*T +: T] == tag) begin
                hit = 1;
                d = cdb_data[l*X +: X];
            end
        end
        return hit;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < E; i++) m_v[i] = 0;
        m_cnt = 0;
    endtask

    task automatic idle();
        issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
        issue_qj = 0; issue_qk = 0; issue_dst = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0;
    endtask

    task automatic iss(input logic [O-1:0] op, input logic [X-1:0] vj, input logic [T-1:0] qj,
                       input logic [X-1:0] vk, input logic [T-1:0] qk, input logic [T-1:0] dst);
        issue_valid = 1; issue_op = op; issue_vj = vj; issue_qj = qj;
        issue_vk = vk; issue_qk = qk; issue_dst = dst;
    endtask

    task automatic bcast(input int lane, input logic [T-1:0] tag, input logic [X-1:0] data);
        cdb_valid[lane] = 1'b1;
        cdb_tag[lane*T +: T] = tag;
        cdb_data[lane*X +: X] = data;
    endtask

    // Check outputs against the model for the current inputs, advance the model, step one clock.
    task automatic cycle();
        int sel, free;
        bit exp_dv, fd, fi;
        logic [X-1:0] d;
        #1;
        sel = -1;
        for (int i = 0; i < E; i++) begin
            if (m_v[i] && m_qj[i] == 0 && m_qk[i] == 0) begin
`ifdef RS_AGE_ORDER_EN
                if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
        end
        exp_dv = sel >= 0 && !flush;
        check("issue_ready", issue_ready, m_cnt < E);
        check("count", count, m_cnt);
        check("disp_valid", disp_valid, exp_dv);
        if (exp_dv) begin
            check("disp_op", disp_op, m_op[sel]);
            check("disp_vj", disp_vj, m_vj[sel]);
            check("disp_vk", disp_vk, m_vk[sel]);
            check("disp_dst", disp_dst, m_dst[sel]);
        end
        fd = exp_dv && disp_ready;
        fi = issue_valid && m_cnt < E && !flush;
        if (flush) begin
            model_clear();
        end else begin
            free = -1;
            for (int i = 0; i < E; i++) if (!m_v[i] && free < 0) free = i;
            for (int i = 0; i < E; i++) begin
                if (m_v[i] && lane_hit(m_qj[i], d)) begin m_vj[i] = d; m_qj[i] = 0; end
                if (m_v[i] && lane_hit(m_qk[i], d)) begin m_vk[i] = d; m_qk[i] = 0; end
            end
            if (fd) m_v[sel] = 0;
            if (fi) begin
                m_v[free] = 1; m_op[free] = issue_op; m_dst[free] = issue_dst;
                m_vj[free] = issue_vj; m_qj[free] = issue_qj;
                m_vk[free] = issue_vk; m_qk[free] = issue_qk;
                if (lane_hit(issue_qj, d)) begin m_vj[free] = d; m_qj[free] = 0; end
                if (lane_hit(issue_qk, d)) begin m_vk[free] = d; m_qk[free] = 0; end
                m_seq[free] = seqc++;
            end
            m_cnt = m_cnt + int'(fi) - int'(fd);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        n_chk = 0; n_fail = 0; seqc = 0;
        rst_n = 0; disp_ready = 0;
        idle();
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_disp_fields", {disp_op, disp_vj, disp_vk, disp_dst}, 0);
        @(negedge clk);
        rst_n = 1;

        // simple ready issue then dispatch
        iss(1, 5, 0, 7, 0, 3);
        cycle();
        disp_ready = 1;
        #1;
        check("t1_dv", disp_valid, 1);
        check("t1_op", disp_op, 1);
        check("t1_vj", disp_vj, 5);
        check("t1_vk", disp_vk, 7);
        check("t1_dst", disp_dst, 3);
        check("t1_cnt", count, 1);
        cycle();
        #1;
        check("t1_cnt_after", count, 0);

        // wakeup from lane 1
        iss(2, 0, 6, 4, 0, 1);
        cycle();
        cycle();
        bcast(1, 6, 32'h10);
        #1;
        check("t2_dv_wait", disp_valid, 0);
        cycle();
        #1;
        check("t2_dv", disp_valid, 1);
        check("t2_vj", disp_vj, 32'h10);
        check("t2_dst", disp_dst, 1);
        cycle();

        // issue-time bypass from lane 0
        iss(3, 0, 9, 8, 0, 5);
        bcast(0, 9, 32'hAA);
        cycle();
        #1;
        check("t3_dv", disp_valid, 1);
        check("t3_vj", disp_vj, 32'hAA);
        check("t3_vk", disp_vk, 8);
        check("t3_dst", disp_dst, 5);
        cycle();

        // fill, hold, broadcast, dispatch in issue order
        disp_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            iss(4, k, 0, 0, 2, k);
            cycle();
        end
        #1;
        check("t4_ir", issue_ready, 0);
        check("t4_cnt", count, 4);
        check("t4_dv", disp_valid, 0);
        bcast(0, 2, 32'h55);
        cycle();
        disp_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("t4_order", disp_dst, k);
            check("t4_vk", disp_vk, 32'h55);
            cycle();
        end
        #1;
        check("t4_cnt_end", count, 0);

        // full bank with simultaneous dispatch refuses issue
        disp_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            iss(5, k, 0, k, 0, 4'(k + 8));
            cycle();
        end
        disp_ready = 1;
        iss(6, 1, 0, 1, 0, 9);
        #1;
        check("t5_ir_full", issue_ready, 0);
        cycle();
        #1;
        check("t5_cnt", count, 3);
        disp_ready = 0;
        iss(6, 1, 0, 1, 0, 9);
        #1;
        check("t5_ir_free", issue_ready, 1);
        cycle();
        #1;
        check("t5_cnt_refill", count, 4);
        disp_ready = 1;
        repeat (5) cycle();

        // flush with waiting entries
        for (int k = 1; k <= 3; k++) begin
            iss(7, 0, 5, 0, 0, k);
            cycle();
        end
        flush = 1;
        #1;
        check("t6_dv_flush", disp_valid, 0);
        cycle();
        #1;
        check("t6_cnt", count, 0);
        check("t6_dv", disp_valid, 0);
        bcast(0, 5, 1);
        cycle();
        #1;
        check("t6_no_disp", disp_valid, 0);

        // randomized traffic
        repeat (3000) begin
            disp_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 2) != 0)
                iss(O'($urandom), $urandom, ($urandom_range(0, 1) != 0) ? T'($urandom_range(1, 7)) : T'(0),
                    $urandom, ($urandom_range(0, 1) != 0) ? T'($urandom_range(1, 7)) : T'(0),
                    T'($urandom_range(1, 15)));
            for (int l = 0; l < N; l++)
                if ($urandom_range(0, 1) != 0) bcast(l, T'($urandom_range(1, 7)), $urandom);
            cycle();
        end

        // asynchronous reset mid-operation
        disp_ready = 0;
        for (int k = 1; k <= 3; k++) begin
            iss(8, k, 0, k, 0, k);
            cycle();
        end
        #2;
        rst_n = 0;
        #1;
        check("mrst_count", count, 0);
        check("mrst_ir", issue_ready, 1);
        check("mrst_dv", disp_valid, 0);
        check("mrst_fields", {disp_op, disp_vj, disp_vk, disp_dst}, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_bank.md
# rs_bank

Parametrised reservation-station bank for the Tomasulo core: holds up to ENTRIES issued operations waiting on operands, snoops CDB_N common-data-bus lanes to capture results by tag, and dispatches one ready operation per cycle to its execution unit. It replaces the fixed per-unit ADD/MULT station slots with one configurable-depth bank instantiated per functional-unit class. It sits between the order manager/register-file issue path and an EXE_add or EXE_mul unit.

## Interface
- ENTRIES, 4: station slots (≥2).
- XLEN, 32: operand/result width.
- TAG_W, 4: rename tag width; tag 0 is reserved and means "value present".
- OP_W, 4: opcode width.
- CDB_N, 2: number of CDB broadcast lanes.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries (mispredict/exception).
- issue_valid  in  1  issue request.
- issue_ready  out  1  bank can accept; high when count < ENTRIES.
- issue_op  in  OP_W  opcode.
- issue_vj, issue_vk  in  XLEN  operand values (used when matching tag is 0).
- issue_qj, issue_qk  in  TAG_W  producer tags; 0 = operand already valid.
- issue_dst  in  TAG_W  destination tag (ROB index), nonzero.
- cdb_valid  in  CDB_N  per-lane broadcast valid.
- cdb_tag  in  CDB_N*TAG_W  lane i at bits [i*TAG_W +: TAG_W].
- cdb_data  in  CDB_N*XLEN  lane i at bits [i*XLEN +: XLEN].
- disp_valid  out  1  a ready entry is presented.
- disp_ready  in  1  EXE unit accepts.
- disp_op  out  OP_W; disp_vj, disp_vk  out  XLEN; disp_dst  out  TAG_W  dispatched entry fields.
- count  out  $clog2(ENTRIES+1)  occupied entries.

## Operation
- Entry state: valid, op, vj, qj, vk, qk, dst, age ($clog2(ENTRIES) bits).
- Issue (issue_valid & issue_ready & !flush): write lowest-index entry free at cycle start; age 0; every other valid entry age +1.
- Issue-time bypass: if issue_qj (or qk) is nonzero and equals a valid lane's cdb_tag in the same cycle, store that lane's data and tag 0.
- Wakeup: each valid entry with qj≠0 compares against all lanes; on match capture cdb_data, set qj=0. Same for qk independently; one lane may wake both operands.
- Multiple lanes with equal tag: lowest lane index wins (protocol error; no fault raised).
- Ready = valid & qj==0 & qk==0, from registered state only.
- Dispatch select: oldest ready entry (largest age). Output fields driven combinationally from the selected entry.
- Handshake: disp_valid & disp_ready frees the entry at clock edge; ages of younger entries unchanged (ordering preserved, values stay unique).
- Flush: all valid cleared next edge; issue ignored; disp_valid forced 0 during flush cycle.
- count: +1 on issue, −1 on dispatch, unchanged when both, 0 after flush.

## Timing
- Reset: all entries invalid, count=0, issue_ready=1, disp_valid=0, disp_op/vj/vk/dst=0.
- Issue with both tags 0 (or bypassed): dispatchable the next cycle.
- CDB match in cycle N: entry ready, disp_valid may assert in N+1.
- issue_ready is from registered count: full bank with simultaneous dispatch still refuses issue that cycle; freed slot reusable next cycle.
- disp_valid with disp_ready low: selection may change only if an older entry becomes ready; no entry lost.
- Reset asserted mid-operation: all entries dropped immediately, outputs to reset values.

## Configuration
- RS_AGE_ORDER_EN defined: age fields kept, dispatch oldest ready entry as above.
- Not defined: no age storage; dispatch picks lowest-index ready entry; all other behaviour identical.

## Test plan
- ENTRIES=4, CDB_N=2, TAG_W=4. Issue op=1, qj=qk=0, vj=5, vk=7, dst=3 -> next cycle disp_valid=1, vj=5, vk=7, dst=3; count 1->0 on accept.
- Issue dst=1 qj=6; two cycles later cdb lane1 tag=6 data=0x10 -> following cycle disp_vj=0x10, disp_valid=1.
- Issue qj=9 while lane0 broadcasts tag 9 data=0xAA same cycle -> entry stored ready, dispatch next cycle with vj=0xAA.
- Fill 4 entries with qk=2, hold disp_ready=0 -> issue_ready=0, count=4; broadcast tag 2 -> with RS_AGE_ORDER_EN dispatch order equals issue order dst 1,2,3,4.
- Full bank, dispatch and issue same cycle -> issue refused, count=3, new issue accepted next cycle.
- Three entries waiting, assert flush one cycle -> count=0, disp_valid=0, later tag broadcast causes no dispatch.
